// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and widths for the time-shared 4x4 multiplier controller.
package mult_share_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 8;

    // 2'b11 is unused; the FSM treats it as a fault and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester/consumer bus of the shared multiplier: per-requester request lanes plus one response lane.
interface mult_share_ctrl_if #(
    parameter int N_REQ = 4
);
    import mult_share_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [RES_W-1:0]      rsp_c;
    logic [ID_W-1:0]       rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_id
    );

endinterface

// File: rtl/mult_share_ctrl_mult.sv
// Unsigned full-width multiplier datapath shared by all requesters.
module multiplier #(
    parameter int A_W = 4,
    parameter int B_W = 4
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    assign p = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};

endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first valid bit at or above ptr, wrapping past N-1.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    // cand_idx[k] is the requester examined k-th, i.e. (ptr + k) mod N.
    logic [ID_W-1:0] cand_idx [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N)) : sum[ID_W-1:0];
    end

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Walk from farthest to nearest so the nearest valid candidate wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[cand_idx[k]]) begin
                idx = cand_idx[k];
                any = 1'b1;
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin time-sharing controller for one 4x4 multiplier: one operation in flight,
// registered operands and result, IDLE -> CALC -> RESP per operation.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_share_ctrl_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);

    state_t           state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [OP_W-1:0]  a_reg;
    logic [OP_W-1:0]  b_reg;
    logic [ID_W-1:0]  id_reg;
    logic [RES_W-1:0] rsp_c_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic             rsp_valid_reg;

    logic [N_REQ-1:0] arb_grant;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic             accept;
    logic [ID_W-1:0]  rr_ptr_next;
    logic [RES_W-1:0] prod;

    logic [OP_W-1:0]  a_lane [N_REQ];
    logic [OP_W-1:0]  b_lane [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign a_lane[gi] = bus.req_a[gi*OP_W +: OP_W];
        assign b_lane[gi] = bus.req_b[gi*OP_W +: OP_W];
    end

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // The grant is offered combinationally so an accept costs no extra cycle in IDLE.
    assign bus.req_ready = (state_reg == IDLE && arb_any) ? arb_grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign rr_ptr_next   = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

    multiplier #(
        .A_W (OP_W),
        .B_W (OP_W)
    ) u_mult (
        .a (a_reg),
        .b (b_reg),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_c_reg     <= '0;
            rsp_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= a_lane[arb_idx];
                        b_reg      <= b_lane[arb_idx];
                        id_reg     <= arb_idx;
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    rsp_c_reg     <= prod;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    // Leaving RESP always passes through IDLE before the next grant.
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_c     = rsp_c_reg;
    assign bus.rsp_id    = rsp_id_reg;

endmodule
